// File: rtl/dpsystem_pkg.sv
// Shared widths, frame constants and FSM encoding for the dpsystem result path.
package dpsystem_pkg;

  localparam int unsigned n = 8;
  localparam int unsigned m = 10;
  localparam int unsigned k = 12;

  function automatic int unsigned calcPw(input int unsigned tagW, input int unsigned sampW,
                                         input int unsigned accW);
    return tagW + sampW + sampW + accW;
  endfunction

  function automatic int unsigned calcNBytes(input int unsigned width);
    return (width + 7) / 8;
  endfunction

  localparam int unsigned PW     = calcPw(m, n, k);
  localparam int unsigned NBYTES = calcNBytes(PW);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Result word layout {tag, min, max, acc}, shared with the FIFO writer.
  localparam int unsigned AccLsb = 0;
  localparam int unsigned MaxLsb = AccLsb + k;
  localparam int unsigned MinLsb = MaxLsb + n;
  localparam int unsigned TagLsb = MinLsb + n;

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StLatch,
    StSend
  } packerState_e;

endpackage

// File: rtl/dpsystem_byte_shifter.sv
// Loadable shift-left-by-8 register exposing its top two bytes and a running XOR
// of every byte shifted out.
module dpsystem_byte_shifter #(
  parameter int unsigned NBytes = 5
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  load_i,
  input  logic [8*NBytes-1:0]   loadData_i,
  input  logic [7:0]            loadXor_i,
  input  logic                  shift_i,
  output logic [7:0]            msbByte_o,
  output logic [7:0]            nextByte_o,
  output logic [7:0]            xorAcc_o
);

  logic [8*NBytes-1:0] shiftReg_q;
  logic [7:0]          xorAcc_q;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      shiftReg_q <= '0;
      xorAcc_q   <= 8'h00;
    end else if (load_i) begin
      shiftReg_q <= loadData_i;
      xorAcc_q   <= loadXor_i;
    end else if (shift_i) begin
      shiftReg_q <= shiftReg_q << 8;
      xorAcc_q   <= xorAcc_q ^ msbByte_o;
    end
  end

  assign msbByte_o  = shiftReg_q[8*NBytes-1 -: 8];
  assign nextByte_o = shiftReg_q[8*NBytes-9 -: 8];
  assign xorAcc_o   = xorAcc_q;

endmodule

// File: rtl/dpsystem_result_packer.sv
// Drains the result FIFO one word at a time and sends each word as a byte frame:
// SYNC, SEQ, payload bytes MSB first, CHK (XOR of SEQ and payload).
module dpsystem_result_packer
  import dpsystem_pkg::*;
(
  input  logic          Clock,
  input  logic          nReset,
  input  logic          Enable,
  input  logic          FifoState_empty,
  output logic          ReadEna,
  input  logic [PW-1:0] ReadData,
  output logic [7:0]    TxData,
  output logic          TxValid,
  input  logic          TxReady,
  output logic          Busy,
  output logic [7:0]    FrameCount
);

  localparam int unsigned LastIdx = NBYTES + 2;
  localparam int unsigned IdxW    = $clog2(LastIdx + 1);

  packerState_e          state;
  logic [IdxW-1:0]       byteIdx;
  logic [7:0]            seq;
  logic [8*NBYTES-1:0]   loadWord;
  logic                  txAccept;
  logic                  shiftAdv;
  logic [7:0]            msbByte;
  logic [7:0]            nextByte;
  logic [7:0]            xorAcc;
  logic [7:0]            txNext;

  always_comb begin
    loadWord           = '0;
    loadWord[PW-1:0]   = ReadData;
  end

  // TxValid is high for the whole of SEND, so acceptance only needs TxReady.
  assign txAccept = (state == StSend) && TxReady;
  assign shiftAdv = txAccept && (byteIdx >= IdxW'(2)) && (byteIdx <= IdxW'(NBYTES + 1));

  dpsystem_byte_shifter #(
    .NBytes (NBYTES)
  ) u_shifter (
    .Clock      (Clock),
    .nReset     (nReset),
    .load_i     (state == StLatch),
    .loadData_i (loadWord),
    .loadXor_i  (seq),
    .shift_i    (shiftAdv),
    .msbByte_o  (msbByte),
    .nextByte_o (nextByte),
    .xorAcc_o   (xorAcc)
  );

  // Byte to present once the current byteIdx is accepted.
  always_comb begin
    txNext = nextByte;
    if (byteIdx == '0) begin
      txNext = seq;
    end else if (byteIdx == IdxW'(1)) begin
      txNext = msbByte;
    end else if (byteIdx == IdxW'(NBYTES + 1)) begin
      txNext = xorAcc ^ msbByte;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state      <= StIdle;
      ReadEna    <= 1'b0;
      TxValid    <= 1'b0;
      TxData     <= 8'h00;
      Busy       <= 1'b0;
      FrameCount <= 8'h00;
      seq        <= 8'h00;
      byteIdx    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (Enable && !FifoState_empty) begin
            state   <= StPop;
            ReadEna <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        StPop: begin
          ReadEna <= 1'b0;
          state   <= StLatch;
        end
        StLatch: begin
          state   <= StSend;
          byteIdx <= '0;
          TxValid <= 1'b1;
          TxData  <= SYNC_BYTE;
        end
        StSend: begin
          if (txAccept) begin
            if (byteIdx == IdxW'(LastIdx)) begin
              state      <= StIdle;
              TxValid    <= 1'b0;
              TxData     <= 8'h00;
              Busy       <= 1'b0;
              seq        <= seq + 8'd1;
              FrameCount <= FrameCount + 8'd1;
            end else begin
              byteIdx <= byteIdx + IdxW'(1);
              TxData  <= txNext;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dpsystem_result_packer.sv
// Self-checking bench for dpsystem_result_packer: FIFO and sink models, frame reference model.
module tb_dpsystem_result_packer;
  import dpsystem_pkg::*;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          Enable = 1'b0;
  logic          FifoState_empty = 1'b1;
  logic          ReadEna;
  logic [PW-1:0] ReadData = '0;
  logic [7:0]    TxData;
  logic          TxValid;
  logic          TxReady = 1'b0;
  logic          Busy;
  logic [7:0]    FrameCount;

  dpsystem_result_packer dut (
    .Clock           (Clock),
    .nReset          (nReset),
    .Enable          (Enable),
    .FifoState_empty (FifoState_empty),
    .ReadEna         (ReadEna),
    .ReadData        (ReadData),
    .TxData          (TxData),
    .TxValid         (TxValid),
    .TxReady         (TxReady),
    .Busy            (Busy),
    .FrameCount      (FrameCount)
  );

  initial forever #5 Clock = ~Clock;

  int total = 0;
  int passed = 0;

  logic [PW-1:0] fifoQ[$];
  logic [7:0]    rxQ[$];
  logic [7:0]    expQ[$];
  int            rxCyc[$];
  int            popCyc[$];
  int            cyc = 0;
  int            popCount = 0;
  int            lastPopCycle = 0;
  int            lastLatency = -1;
  int            stallViol = 0;
  int            emptyPopViol = 0;
  int            doublePopViol = 0;
  logic [15:0]   readyPat = 16'hFFFF;
  int            readyBase = 0;
  logic [7:0]    expSeq = 8'h00;

  always @(negedge Clock) TxReady = readyPat[4'((cyc - readyBase) % 16)];

  // FIFO model and byte sink: empty flag refreshed after stimulus, outputs sampled 1ns
  // before each rising edge.
  logic       prevStall = 1'b0;
  logic       prevValid = 1'b0;
  logic       prevReadEna = 1'b0;
  logic [7:0] prevData = 8'h00;
  always begin
    @(negedge Clock);
    #2;
    FifoState_empty = (fifoQ.size() == 0);
    #2;
    cyc++;
    if (nReset) begin
      if (ReadEna) begin
        if (fifoQ.size() == 0) emptyPopViol++;
        else ReadData = fifoQ.pop_front();
        if (prevReadEna) doublePopViol++;
        popCount++;
        popCyc.push_back(cyc);
        lastPopCycle = cyc;
      end
      if (prevStall && !(TxValid && TxData == prevData)) stallViol++;
      if (TxValid && !prevValid) lastLatency = cyc - lastPopCycle;
      if (TxValid && TxReady) begin
        rxQ.push_back(TxData);
        rxCyc.push_back(cyc);
      end
      prevStall   = TxValid && !TxReady;
      prevData    = TxData;
      prevValid   = TxValid;
      prevReadEna = ReadEna;
    end else begin
      prevStall   = 1'b0;
      prevValid   = 1'b0;
      prevReadEna = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference frame: sync, seq, payload bytes from the top of the zero-padded word, checksum.
  task automatic expectFrame(input logic [PW-1:0] word);
    longint unsigned v;
    logic [7:0] b;
    logic [7:0] chk;
    v = longint'(word);
    chk = expSeq;
    expQ.push_back(8'hA5);
    expQ.push_back(expSeq);
    for (int i = 0; i < NBYTES; i++) begin
      b = 8'((v >> (8 * (NBYTES - 1 - i))) & 64'hFF);
      expQ.push_back(b);
      chk = chk ^ b;
    end
    expQ.push_back(chk);
    expSeq = expSeq + 8'd1;
  endtask

  task automatic compareStream(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    check({name, " length"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      if (rxQ[i] !== expQ[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0) $display("  %s: first differing byte %0d got %h want %h", name, first,
                           rxQ[first], expQ[first]);
    check({name, " bytes"}, bad, 0);
    rxQ.delete();
    expQ.delete();
    rxCyc.delete();
  endtask

  task automatic waitBytes(input int cnt, input int budget);
    int b;
    b = budget;
    while (rxQ.size() < cnt && b > 0) begin
      @(negedge Clock);
      b--;
    end
    if (rxQ.size() < cnt) check("timeout waiting for bytes", rxQ.size(), cnt);
  endtask

  task automatic setReady(input logic [15:0] pat);
    readyPat = pat;
    readyBase = cyc;
  endtask

  typedef struct {
    logic [PW-1:0] word;
    logic [15:0]   pat;
    logic [7:0]    expChk;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int pc0;
    int pi0;
    logic [PW-1:0] w1;
    logic [PW-1:0] w2;

    vecs[0] = '{38'h00F76E3ABC, 16'hFFFF, 8'h1F};
    vecs[1] = '{38'h00F76E3ABC, 16'h9999, 8'h1E};
    vecs[2] = '{38'h3FFFFFFFFF, 16'h5555, 8'h3D};
    vecs[3] = '{38'h0000000000, 16'hFFFF, 8'h03};
    vecs[4] = '{38'h2A5A5A5A5A, 16'h3333, 8'h2E};

    repeat (3) @(negedge Clock);
    check("reset ReadEna", ReadEna, 0);
    check("reset TxValid", TxValid, 0);
    check("reset TxData", TxData, 0);
    check("reset Busy", Busy, 0);
    check("reset FrameCount", FrameCount, 0);
    nReset = 1'b1;
    Enable = 1'b1;

    for (int i = 0; i < 5; i++) begin
      setReady(vecs[i].pat);
      pc0 = popCount;
      fifoQ.push_back(vecs[i].word);
      expectFrame(vecs[i].word);
      waitBytes(8, 200);
      repeat (2) @(negedge Clock);
      check("table CHK byte", rxQ[7], vecs[i].expChk);
      check("table FrameCount", FrameCount, 64'(i + 1));
      check("table pops per frame", popCount - pc0, 1);
      check("table first TxValid latency", lastLatency, 2);
      check("table Busy after frame", Busy, 0);
      if (vecs[i].pat == 16'hFFFF) check("table consecutive bytes", rxCyc[7] - rxCyc[0], 7);
      compareStream("table frame");
    end

    // Three words queued together: frames back to back with one idle cycle between.
    setReady(16'hFFFF);
    pi0 = popCyc.size();
    for (int i = 0; i < 3; i++) begin
      w1 = PW'({$urandom, $urandom});
      fifoQ.push_back(w1);
      expectFrame(w1);
    end
    waitBytes(24, 400);
    repeat (2) @(negedge Clock);
    check("b2b pop spacing 0-1", popCyc[pi0 + 1] - popCyc[pi0], NBYTES + 6);
    check("b2b pop spacing 1-2", popCyc[pi0 + 2] - popCyc[pi0 + 1], NBYTES + 6);
    compareStream("b2b frames");

    // Enable dropped mid-frame: current frame finishes, nothing else popped.
    pc0 = popCount;
    w1 = PW'({$urandom, $urandom});
    w2 = PW'({$urandom, $urandom});
    fifoQ.push_back(w1);
    fifoQ.push_back(w2);
    expectFrame(w1);
    waitBytes(3, 100);
    Enable = 1'b0;
    waitBytes(8, 100);
    repeat (20) @(negedge Clock);
    check("enable-drop pops", popCount - pc0, 1);
    check("enable-drop Busy", Busy, 0);
    check("enable-drop TxValid", TxValid, 0);
    check("enable-drop fifo level", fifoQ.size(), 1);
    compareStream("enable-drop frame");
    Enable = 1'b1;
    expectFrame(w2);
    waitBytes(8, 200);
    compareStream("enable-resume frame");

    // Randomised backpressure and data.
    for (int bt = 0; bt < 4; bt++) begin
      setReady(16'($urandom) | 16'h0001);
      for (int i = 0; i < 5; i++) begin
        w1 = PW'({$urandom, $urandom});
        fifoQ.push_back(w1);
        expectFrame(w1);
      end
      waitBytes(40, 3000);
      compareStream("random batch");
    end

    // Reset pulse mid-frame aborts it; next frame restarts at SEQ 0 with a fresh pop.
    repeat (2) @(negedge Clock);
    setReady(16'hFFFF);
    fifoQ.push_back(PW'({$urandom, $urandom}));
    waitBytes(4, 100);
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    #1;
    check("mid-reset TxValid", TxValid, 0);
    check("mid-reset FrameCount", FrameCount, 0);
    check("mid-reset Busy", Busy, 0);
    check("mid-reset word discarded", fifoQ.size(), 0);
    rxQ.delete();
    expQ.delete();
    rxCyc.delete();
    expSeq = 8'h00;
    pc0 = popCount;
    w1 = PW'({$urandom, $urandom});
    fifoQ.push_back(w1);
    expectFrame(w1);
    waitBytes(8, 200);
    repeat (2) @(negedge Clock);
    check("post-reset SEQ", rxQ[1], 8'h00);
    check("post-reset pops", popCount - pc0, 1);
    compareStream("post-reset frame");

    // 255 more frames bring the total since reset to 256: counter wraps, SEQ wraps.
    setReady(16'($urandom) | 16'h1111);
    for (int i = 0; i < 255; i++) begin
      w1 = PW'({$urandom, $urandom});
      fifoQ.push_back(w1);
      expectFrame(w1);
    end
    waitBytes(255 * 8, 255 * 60);
    repeat (2) @(negedge Clock);
    check("FrameCount wrap", FrameCount, 0);
    compareStream("wrap frames");
    w1 = PW'({$urandom, $urandom});
    fifoQ.push_back(w1);
    expectFrame(w1);
    waitBytes(8, 400);
    repeat (2) @(negedge Clock);
    check("frame 257 SEQ", rxQ[1], 8'h00);
    check("FrameCount after wrap", FrameCount, 1);
    compareStream("frame 257");

    check("pop while FIFO empty", emptyPopViol, 0);
    check("ReadEna wider than one cycle", doublePopViol, 0);
    check("TxData stable while stalled", stallViol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
